// File: rtl/scale_sequencer.sv
// scale_sequencer: debounces the decoder request {decoding, opcode, sw},
// launches one ROM->RAM scaling copy per stable setting, holds the copier
// configuration for the whole job and ping-pongs the two framebuffer banks.
// Optional macro SCALE_SEQ_VBLANK_SYNC_EN: when defined, bank swap / display
// select waits for a frame_start pulse (vertical blank); when undefined the
// swap follows copy completion immediately and frame_start is unused.
module scale_sequencer #(
   parameter int unsigned STABLE_CYCLES  = 16,
   parameter int unsigned TIMEOUT_CYCLES = 1048576,
   parameter int unsigned TCNT_W         = 21
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [2:0] opcode,
   input  logic       decoding,
   input  logic       sw,
   input  logic       frame_start,
   input  logic       copy_done,
   output logic       copy_start,
   output logic [2:0] cfg_opcode,
   output logic       cfg_sw,
   output logic       cfg_decoding,
   output logic       wr_bank,
   output logic       rd_bank,
   output logic       show_ram,
   output logic       busy,
   output logic       error
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETTLE,
      S_START,
      S_COPY,
      S_WAIT_VBL,
      S_SWAP
   } state_t;

   localparam logic [TCNT_W-1:0] STABLE_LAST  = TCNT_W'(STABLE_CYCLES - 1);
   localparam logic [TCNT_W-1:0] TIMEOUT_LAST = TCNT_W'(TIMEOUT_CYCLES - 1);

   state_t            state_q, state_d;
   logic [4:0]        app_q, app_d;
   logic [4:0]        cand_q, cand_d;
   logic [2:0]        cfg_opcode_q, cfg_opcode_d;
   logic              cfg_sw_q, cfg_sw_d;
   logic              cfg_decoding_q, cfg_decoding_d;
   logic              wr_bank_q, wr_bank_d;
   logic              rd_bank_q, rd_bank_d;
   logic              show_ram_q, show_ram_d;
   logic              error_q, error_d;
   logic [TCNT_W-1:0] cnt_q, cnt_d;
   logic [TCNT_W-1:0] cnt_inc;
   logic [4:0]        req;

   // Packed request: bit 4 decoding, bits 3:1 opcode, bit 0 sw.
   assign req = {decoding, opcode, sw};

`ifndef SCALE_SEQ_VBLANK_SYNC_EN
   logic unused_frame_start;
   assign unused_frame_start = frame_start;
`endif

   // Saturating increment of the settle/timeout counter.
   always_comb begin
      cnt_inc = cnt_q;
      if (cnt_q != '1) begin
         cnt_inc = cnt_q + TCNT_W'(1);
      end
   end

   // Next-state and register update logic for the sequencer FSM.
   always_comb begin
      state_d        = state_q;
      app_d          = app_q;
      cand_d         = cand_q;
      cfg_opcode_d   = cfg_opcode_q;
      cfg_sw_d       = cfg_sw_q;
      cfg_decoding_d = cfg_decoding_q;
      wr_bank_d      = wr_bank_q;
      rd_bank_d      = rd_bank_q;
      show_ram_d     = show_ram_q;
      error_d        = error_q;
      cnt_d          = cnt_q;

      case (state_q)
         S_IDLE: begin
            if (req != app_q) begin
               cand_d  = req;
               cnt_d   = '0;
               state_d = S_SETTLE;
            end
         end
         S_SETTLE: begin
            if (req != cand_q) begin
               cand_d = req;
               cnt_d  = '0;
            end else if (cnt_q == STABLE_LAST) begin
               if (cand_q == app_q) begin
                  state_d = S_IDLE;
               end else if (!cand_q[4]) begin
`ifdef SCALE_SEQ_VBLANK_SYNC_EN
                  state_d = S_WAIT_VBL;
`else
                  state_d = S_SWAP;
`endif
               end else begin
                  state_d = S_START;
               end
            end else begin
               cnt_d = cnt_inc;
            end
         end
         S_START: begin
            cfg_decoding_d = cand_q[4];
            cfg_opcode_d   = cand_q[3:1];
            cfg_sw_d       = cand_q[0];
            cnt_d          = '0;
            state_d        = S_COPY;
         end
         S_COPY: begin
            if (copy_done) begin
`ifdef SCALE_SEQ_VBLANK_SYNC_EN
               state_d = S_WAIT_VBL;
`else
               state_d = S_SWAP;
`endif
            end else if (cnt_q == TIMEOUT_LAST) begin
               // Committing the candidate stops an endless retry of a dead job.
               error_d = 1'b1;
               app_d   = cand_q;
               state_d = S_IDLE;
            end else begin
               cnt_d = cnt_inc;
            end
         end
`ifdef SCALE_SEQ_VBLANK_SYNC_EN
         S_WAIT_VBL: begin
            if (frame_start) begin
               state_d = S_SWAP;
            end
         end
`endif
         S_SWAP: begin
            app_d      = cand_q;
            show_ram_d = cand_q[4];
            if (cand_q[4]) begin
               rd_bank_d = wr_bank_q;
               wr_bank_d = ~wr_bank_q;
            end else begin
               cfg_decoding_d = 1'b0;
            end
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and configuration registers with synchronous reset.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q        <= S_IDLE;
         app_q          <= '0;
         cand_q         <= '0;
         cfg_opcode_q   <= '0;
         cfg_sw_q       <= 1'b0;
         cfg_decoding_q <= 1'b0;
         wr_bank_q      <= 1'b1;
         rd_bank_q      <= 1'b0;
         show_ram_q     <= 1'b0;
         error_q        <= 1'b0;
         cnt_q          <= '0;
      end else begin
         state_q        <= state_d;
         app_q          <= app_d;
         cand_q         <= cand_d;
         cfg_opcode_q   <= cfg_opcode_d;
         cfg_sw_q       <= cfg_sw_d;
         cfg_decoding_q <= cfg_decoding_d;
         wr_bank_q      <= wr_bank_d;
         rd_bank_q      <= rd_bank_d;
         show_ram_q     <= show_ram_d;
         error_q        <= error_d;
         cnt_q          <= cnt_d;
      end
   end

   assign copy_start   = (state_q == S_START);
   assign busy         = (state_q != S_IDLE);
   assign cfg_opcode   = cfg_opcode_q;
   assign cfg_sw       = cfg_sw_q;
   assign cfg_decoding = cfg_decoding_q;
   assign wr_bank      = wr_bank_q;
   assign rd_bank      = rd_bank_q;
   assign show_ram     = show_ram_q;
   assign error        = error_q;

endmodule

// File: tb/tb_scale_sequencer.sv
// Directed self-checking bench for scale_sequencer (STABLE_CYCLES=4,
// TIMEOUT_CYCLES=64). Expectations follow SCALE_SEQ_VBLANK_SYNC_EN.
module tb_scale_sequencer;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic [2:0] opcode = '0;
   logic       decoding = 1'b0;
   logic       sw = 1'b0;
   logic       frame_start = 1'b0;
   logic       copy_done = 1'b0;
   logic       copy_start;
   logic [2:0] cfg_opcode;
   logic       cfg_sw;
   logic       cfg_decoding;
   logic       wr_bank;
   logic       rd_bank;
   logic       show_ram;
   logic       busy;
   logic       error;

   int n_total = 0;
   int n_pass  = 0;
   int starts  = 0;

   scale_sequencer #(
      .STABLE_CYCLES (4),
      .TIMEOUT_CYCLES(64),
      .TCNT_W        (21)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .opcode      (opcode),
      .decoding    (decoding),
      .sw          (sw),
      .frame_start (frame_start),
      .copy_done   (copy_done),
      .copy_start  (copy_start),
      .cfg_opcode  (cfg_opcode),
      .cfg_sw      (cfg_sw),
      .cfg_decoding(cfg_decoding),
      .wr_bank     (wr_bank),
      .rd_bank     (rd_bank),
      .show_ram    (show_ram),
      .busy        (busy),
      .error       (error)
   );

   always #5 clock = ~clock;

   // Count launch pulses, sampled away from the active edge.
   always @(negedge clock) begin
      if (copy_start === 1'b1) starts++;
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic set_req(input logic d, input logic [2:0] op, input logic s);
      decoding = d;
      opcode   = op;
      sw       = s;
   endtask

   // Edges until copy_start is seen, bounded at 40.
   task automatic wait_start(output int n);
      n = 0;
      while (copy_start !== 1'b1 && n < 40) begin
         tick();
         n++;
      end
   endtask

   // From COPY: completion pulse, optional vblank, ending one edge after SWAP.
   task automatic finish_job();
      copy_done = 1'b1;
      tick();
      copy_done = 1'b0;
`ifdef SCALE_SEQ_VBLANK_SYNC_EN
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
`endif
      tick();
   endtask

   task automatic test_reset();
      repeat (3) tick();
      n_total++;
      if ({copy_start, busy, error, show_ram, rd_bank, wr_bank} !== 6'b000001)
         $display("FAIL reset_outputs: got %b expected 000001", {copy_start, busy, error, show_ram, rd_bank, wr_bank});
      else n_pass++;
      n_total++;
      if ({cfg_decoding, cfg_opcode, cfg_sw} !== 5'b0)
         $display("FAIL reset_cfg: got %b expected 00000", {cfg_decoding, cfg_opcode, cfg_sw});
      else n_pass++;
      reset = 1'b0;
      tick();
   endtask

   task automatic test_basic();
      int n;
      int s0;
      s0 = starts;
      set_req(1'b1, 3'b001, 1'b0);
      wait_start(n);
      n_total++;
      if (n !== 5) $display("FAIL basic_latency: got %0d expected 5", n);
      else n_pass++;
      tick();
      n_total++;
      if ({cfg_decoding, cfg_opcode, cfg_sw} !== 5'b1_001_0)
         $display("FAIL basic_cfg: got %b expected 10010", {cfg_decoding, cfg_opcode, cfg_sw});
      else n_pass++;
      n_total++;
      if ({copy_start, busy} !== 2'b01 || starts - s0 !== 1)
         $display("FAIL basic_pulse: got start=%b busy=%b pulses=%0d expected 0 1 1", copy_start, busy, starts - s0);
      else n_pass++;
      finish_job();
      n_total++;
      if ({rd_bank, wr_bank, show_ram, busy, error} !== 5'b10100)
         $display("FAIL basic_swap: got %b expected 10100", {rd_bank, wr_bank, show_ram, busy, error});
      else n_pass++;
   endtask

   task automatic test_bounce();
      int n;
      int s0;
      s0 = starts;
      for (int i = 0; i < 10; i++) begin
         set_req(1'b1, (i % 2 == 0) ? 3'b011 : 3'b001, 1'b0);
         repeat (2) tick();
      end
      n_total++;
      if (starts - s0 !== 0 || busy !== 1'b1)
         $display("FAIL bounce_quiet: got pulses=%0d busy=%b expected 0 1", starts - s0, busy);
      else n_pass++;
      set_req(1'b1, 3'b011, 1'b0);
      wait_start(n);
      n_total++;
      if (n !== 5) $display("FAIL bounce_latency: got %0d expected 5", n);
      else n_pass++;
      tick();
      n_total++;
      if (cfg_opcode !== 3'b011 || starts - s0 !== 1)
         $display("FAIL bounce_cfg: got opcode=%b pulses=%0d expected 011 1", cfg_opcode, starts - s0);
      else n_pass++;
      finish_job();
      n_total++;
      if ({rd_bank, wr_bank, show_ram, busy} !== 4'b0110)
         $display("FAIL bounce_swap: got %b expected 0110", {rd_bank, wr_bank, show_ram, busy});
      else n_pass++;
   endtask

   task automatic test_change_in_copy();
      int n;
      set_req(1'b1, 3'b001, 1'b1);
      wait_start(n);
      tick();
      set_req(1'b1, 3'b100, 1'b1);
      repeat (5) tick();
      n_total++;
      if ({cfg_decoding, cfg_opcode, cfg_sw, busy} !== 6'b1_001_1_1)
         $display("FAIL copy_hold_cfg: got %b expected 100111", {cfg_decoding, cfg_opcode, cfg_sw, busy});
      else n_pass++;
      finish_job();
      n_total++;
      if ({cfg_opcode, rd_bank, wr_bank, show_ram, busy} !== 7'b001_1_0_1_0)
         $display("FAIL copy_first_swap: got %b expected 0011010", {cfg_opcode, rd_bank, wr_bank, show_ram, busy});
      else n_pass++;
      wait_start(n);
      n_total++;
      if (n !== 5) $display("FAIL copy_second_latency: got %0d expected 5", n);
      else n_pass++;
      tick();
      n_total++;
      if ({cfg_decoding, cfg_opcode, cfg_sw} !== 5'b1_100_1)
         $display("FAIL copy_second_cfg: got %b expected 11001", {cfg_decoding, cfg_opcode, cfg_sw});
      else n_pass++;
      finish_job();
      n_total++;
      if ({rd_bank, wr_bank, show_ram, busy} !== 4'b0110)
         $display("FAIL copy_second_swap: got %b expected 0110", {rd_bank, wr_bank, show_ram, busy});
      else n_pass++;
   endtask

   task automatic test_timeout();
      int n;
      int s0;
      set_req(1'b1, 3'b010, 1'b1);
      wait_start(n);
      tick();
      s0 = starts;
      repeat (63) tick();
      n_total++;
      if ({busy, error} !== 2'b10)
         $display("FAIL timeout_early: got busy/error=%b expected 10", {busy, error});
      else n_pass++;
      tick();
      n_total++;
      if ({busy, error, rd_bank, wr_bank, show_ram} !== 5'b01011)
         $display("FAIL timeout_fire: got %b expected 01011", {busy, error, rd_bank, wr_bank, show_ram});
      else n_pass++;
      repeat (20) tick();
      n_total++;
      if (starts - s0 !== 0 || busy !== 1'b0)
         $display("FAIL timeout_no_retry: got pulses=%0d busy=%b expected 0 0", starts - s0, busy);
      else n_pass++;
   endtask

   task automatic test_coincident();
      int n;
      set_req(1'b1, 3'b110, 1'b1);
      wait_start(n);
      tick();
      copy_done   = 1'b1;
      frame_start = 1'b1;
      tick();
      copy_done   = 1'b0;
      frame_start = 1'b0;
`ifdef SCALE_SEQ_VBLANK_SYNC_EN
      repeat (3) tick();
      n_total++;
      if ({busy, rd_bank, wr_bank, show_ram} !== 4'b1011)
         $display("FAIL coincident_no_swap: got %b expected 1011", {busy, rd_bank, wr_bank, show_ram});
      else n_pass++;
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
`endif
      tick();
      n_total++;
      if ({busy, rd_bank, wr_bank, show_ram, error} !== 5'b01011)
         $display("FAIL coincident_swap: got %b expected 01011", {busy, rd_bank, wr_bank, show_ram, error});
      else n_pass++;
   endtask

   task automatic test_ram_off();
      int s0;
      s0 = starts;
      set_req(1'b0, 3'b110, 1'b1);
`ifdef SCALE_SEQ_VBLANK_SYNC_EN
      repeat (8) tick();
      n_total++;
      if ({busy, show_ram, rd_bank, wr_bank} !== 4'b1110)
         $display("FAIL ramoff_wait: got %b expected 1110", {busy, show_ram, rd_bank, wr_bank});
      else n_pass++;
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      tick();
`else
      repeat (6) tick();
`endif
      n_total++;
      if ({busy, show_ram, rd_bank, wr_bank, cfg_decoding} !== 5'b00100 || starts - s0 !== 0)
         $display("FAIL ramoff_swap: got %b pulses=%0d expected 00100 0", {busy, show_ram, rd_bank, wr_bank, cfg_decoding}, starts - s0);
      else n_pass++;
      repeat (10) tick();
      n_total++;
      if (busy !== 1'b0 || starts - s0 !== 0)
         $display("FAIL ramoff_idle: got busy=%b pulses=%0d expected 0 0", busy, starts - s0);
      else n_pass++;
   endtask

   task automatic test_reset_midjob();
      int n;
      set_req(1'b1, 3'b111, 1'b0);
      wait_start(n);
      n_total++;
      if (copy_start !== 1'b1) $display("FAIL midreset_setup: got start=%b expected 1", copy_start);
      else n_pass++;
      reset = 1'b1;
      tick();
      n_total++;
      if ({copy_start, busy, error, show_ram, rd_bank, wr_bank} !== 6'b000001 || {cfg_decoding, cfg_opcode, cfg_sw} !== 5'b0)
         $display("FAIL midreset_state: got %b cfg=%b expected 000001 00000", {copy_start, busy, error, show_ram, rd_bank, wr_bank}, {cfg_decoding, cfg_opcode, cfg_sw});
      else n_pass++;
      set_req(1'b0, 3'b000, 1'b0);
      tick();
      reset = 1'b0;
      tick();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_bounce();
      test_change_in_copy();
      test_timeout();
      test_coincident();
      test_ram_off();
      test_reset_midjob();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
